// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a single-ported word memory with
// registered read data. Sub-word stores are a read-modify-write of one word.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic [2:0]            dbg_state_o
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  fault_q;
  logic                  accept;
  logic                  req_fault;
  logic [15:0]           lane;
  logic [31:0]           load_data;
  logic [31:0]           merge_data;
  logic                  unused_addr_bits;

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE, so a held req_valid is taken once per IDLE visit.
  assign accept           = req_valid && req_ready;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    req_fault = 1'b0;
    if (req_write) begin
      case (req_funct3)
        3'b000:  req_fault = 1'b0;
        3'b001:  req_fault = req_addr[0];
        3'b010:  req_fault = |req_addr[1:0];
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_fault = 1'b0;
        3'b001, 3'b101: req_fault = req_addr[0];
        3'b010:         req_fault = |req_addr[1:0];
        default:        req_fault = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_fault)                  state_d = S_DONE;
          else if (!req_write)            state_d = S_RD;
          else if (req_funct3 == 3'b010)  state_d = S_WR;
          else                            state_d = S_RD;
        end
      end
      S_RD:    state_d = write_q ? S_MERGE : S_DONE;
      S_MERGE: state_d = S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_WIDTH+1:0];
        wdata_q  <= req_wdata;
        fault_q  <= req_fault;
      end
    end
  end

  // 16-bit window starting at the addressed byte; halves are aligned here.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane = mem_read_data[15:0];
      2'd1:    lane = mem_read_data[23:8];
      2'd2:    lane = mem_read_data[31:16];
      default: lane = {8'd0, mem_read_data[31:24]};
    endcase
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane};
      default: load_data = mem_read_data;
    endcase
  end

  always_comb begin
    merge_data = mem_read_data;
    if (funct3_q[0]) begin
      if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
      else           merge_data[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merge_data[7:0]   = wdata_q[7:0];
        2'd1:    merge_data[15:8]  = wdata_q[7:0];
        2'd2:    merge_data[23:16] = wdata_q[7:0];
        default: merge_data[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Strobes are gated by rst so a reset landing in MERGE/WR never writes.
  assign req_ready      = (state_q == S_IDLE);
  assign mem_read       = !rst && (state_q == S_RD);
  assign mem_write      = !rst && ((state_q == S_MERGE) || (state_q == S_WR));
  assign resp_valid     = !rst && (state_q == S_DONE);
  assign resp_fault     = (state_q == S_DONE) && fault_q;
  assign resp_rdata     = ((state_q == S_DONE) && !write_q && !fault_q) ? load_data : 32'd0;
  assign mem_address    = addr_q[ADDR_WIDTH+1:2];
  assign mem_write_data = (state_q == S_MERGE) ? merge_data :
                          (state_q == S_WR)    ? wdata_q    : 32'd0;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bench-side memory, spec-level model with
// an expected queue, a per-cycle compare process and a few literal pins.
module tb_load_store_unit;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data = 32'd0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .dbg_state_o(dbg_state)
  );

  // Bench memory the DUT talks to, and the model's own view of it.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] model_mem [0:DEPTH-1];
  logic        init_mem = 1'b1;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= model_mem[i];
    end else begin
      if (mem_write) mem[mem_address] <= mem_write_data;
      if (mem_read)  mem_read_data <= mem[mem_address];
    end
  end

  typedef struct packed {
    logic          fault;
    logic [1:0]    lat;
    logic          do_rd;
    logic          do_wr;
    logic [AW-1:0] addr;
    logic [31:0]   rdata;
    logic [31:0]   wword;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  int   cyc = 0;
  bit   active = 1'b0;
  logic acc_seen = 1'b0;
  logic [31:0] last_rdata = 32'd0, last_wdata = 32'd0;
  logic [AW-1:0] last_waddr = '0;
  logic last_fault = 1'b0;
  int   last_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome of one request, from the width/sign/alignment rules and latencies.
  function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    e = '0;
    e.addr = a[AW+1:2];
    w = model_mem[a[AW+1:2]];
    e.fault = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0) ||
              (wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6));
    if (e.fault) begin
      e.lat = 2'd1;
    end else if (!wr) begin
      e.lat = 2'd2; e.do_rd = 1'b1;
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      case (f3)
        3'd0:    e.rdata = 32'($signed(b));
        3'd1:    e.rdata = 32'($signed(h));
        3'd4:    e.rdata = 32'(b);
        3'd5:    e.rdata = 32'(h);
        default: e.rdata = w;
      endcase
    end else if (f3 == 3'd2) begin
      e.lat = 2'd2; e.do_wr = 1'b1; e.wword = wd;
    end else begin
      e.lat = 2'd3; e.do_rd = 1'b1; e.do_wr = 1'b1;
      if (f3 == 3'd0) begin
        sh = 8 * a[1:0];
        e.wword = (w & ~(32'h000000FF << sh)) | ((wd & 32'h000000FF) << sh);
      end else begin
        sh = 16 * a[1];
        e.wword = (w & ~(32'h0000FFFF << sh)) | ((wd & 32'h0000FFFF) << sh);
      end
    end
    return e;
  endfunction

  always @(posedge clk) acc_seen <= !rst && req_valid && req_ready;

  // Compare process: sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_resp_valid", resp_valid, 0);
      active = 1'b0;
      exp_q.delete();
    end else begin
      if (acc_seen) begin
        chk("single_accept", active, 0);
        chk("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        active = 1'b1;
        cyc = 1;
        n_acc++;
      end else if (active) begin
        cyc++;
      end
      if (active) begin
        chk("mem_read", mem_read, cur.do_rd && cyc == 1);
        chk("mem_write", mem_write, cur.do_wr && cyc == int'(cur.lat) - 1);
        if (mem_read || mem_write) chk("mem_address", mem_address, cur.addr);
        if (mem_write) begin
          chk("mem_write_data", mem_write_data, cur.wword);
          last_wdata = mem_write_data;
          last_waddr = mem_address;
        end
        chk("resp_valid", resp_valid, cyc == int'(cur.lat));
        if (cyc >= int'(cur.lat)) begin
          chk("resp_rdata", resp_rdata, cur.rdata);
          chk("resp_fault", resp_fault, cur.fault);
          last_rdata = resp_rdata;
          last_fault = resp_fault;
          last_lat   = resp_valid ? cyc : -1;
          active = 1'b0;
        end
      end else begin
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_mem_read", mem_read, 0);
        chk("idle_mem_write", mem_write, 0);
        chk("idle_resp_fault", resp_fault, 0);
      end
    end
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit commit);
    exp_t e;
    int   start;
    e = model(wr, f3, a, wd);
    exp_q.push_back(e);
    if (commit && e.do_wr && !e.fault) model_mem[e.addr] = e.wword;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    start = n_acc;
    for (int i = 0; i < 20 && n_acc == start; i++) @(negedge clk);
    chk("accept_seen", n_acc != start, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((active || exp_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", active || exp_q.size() != 0, 0);
    @(negedge clk);
  endtask

  initial begin
    int start;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    model_mem[4] = 32'h8081F2A3;
    model_mem[5] = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_fault", resp_fault, 0);
    chk("reset_resp_rdata", resp_rdata, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_write_data", mem_write_data, 0);

    issue(0, 3'd0, 32'h13, 0, 1); wait_idle();
    chk("lit_lb_0x13", last_rdata, 32'hFFFFFF80);
    chk("lit_lb_latency", last_lat, 2);
    issue(0, 3'd4, 32'h13, 0, 1); wait_idle();
    chk("lit_lbu_0x13", last_rdata, 32'h00000080);
    issue(0, 3'd5, 32'h10, 0, 1); wait_idle();
    chk("lit_lhu_0x10", last_rdata, 32'h0000F2A3);
    issue(0, 3'd1, 32'h12, 0, 1); wait_idle();
    chk("lit_lh_0x12", last_rdata, 32'hFFFF8081);
    issue(0, 3'd0, 32'h11, 0, 1); wait_idle();
    issue(0, 3'd2, 32'h10, 0, 1); wait_idle();

    // Faults: misaligned and illegal encodings, no memory traffic.
    issue(0, 3'd2, 32'h12, 0, 1); wait_idle();
    chk("lit_lw_0x12_fault", last_fault, 1);
    chk("lit_fault_latency", last_lat, 1);
    issue(1, 3'd1, 32'h11, 32'hFFFF, 1); wait_idle();
    chk("lit_sh_0x11_fault", last_fault, 1);
    issue(0, 3'd3, 32'h10, 0, 1); wait_idle();
    issue(1, 3'd4, 32'h10, 32'h1, 1); wait_idle();
    issue(0, 3'd5, 32'h13, 0, 1); wait_idle();

    // Reset during MERGE of SH 0x10: no write may reach memory.
    issue(1, 3'd1, 32'h10, 32'h0000ABCD, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_merge_mem_write", mem_write, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_mem_address", mem_address, 0);
    chk("lit_word4_after_rst", mem[4], 32'h8081F2A3);
    @(negedge clk);

    issue(1, 3'd0, 32'h11, 32'h00000055, 1); wait_idle();
    chk("lit_sb_wdata", last_wdata, 32'h808155A3);
    chk("lit_sb_addr", last_waddr, 4);
    chk("lit_sb_latency", last_lat, 3);
    issue(1, 3'd2, 32'h14, 32'h12345678, 1); wait_idle();
    chk("lit_sw_latency", last_lat, 2);
    issue(0, 3'd2, 32'h14, 0, 1); wait_idle();
    chk("lit_lw_0x14", last_rdata, 32'h12345678);
    issue(1, 3'd1, 32'h16, 32'hDEADBEEF, 1); wait_idle();
    issue(1, 3'd0, 32'h17, 32'h000000C3, 1); wait_idle();
    issue(0, 3'd2, 32'h1000_0014, 0, 1); wait_idle();
    chk("lit_wrap_lw", last_rdata, 32'hC3EF5678);
    issue(0, 3'd1, 32'h16, 0, 1); wait_idle();

    // req_valid held across two loads: one accept per IDLE visit.
    exp_q.push_back(model(0, 3'd0, 32'h14, 0));
    exp_q.push_back(model(0, 3'd0, 32'h14, 0));
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h14;
    start = n_acc;
    for (int i = 0; i < 30 && n_acc < start + 2; i++) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("held_valid_accepts", n_acc - start, 2);

    chk("final_word4", mem[4], model_mem[4]);
    chk("final_word5", mem[5], model_mem[5]);
    chk("final_word0", mem[0], model_mem[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
